// File: rtl/mem_resp_pkg.sv
// Shared types and the request legality check for the data-memory responder.
// The byte-lane rules only matter when MEM_RESP_BYTE_EN is defined; word mode passes be=4'hF.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A request is rejected when the lane pattern is illegal for the address or the word is past the end.
    function automatic logic check_err(input logic [31:0]     addr,
                                       input logic [BE_W-1:0] be,
                                       input logic [31:0]     depth);
        logic misaligned;
        case (be)
            4'b1111:                            misaligned = (addr[1:0] != 2'b00);
            4'b0011, 4'b1100:                   misaligned = addr[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: misaligned = 1'b0;
            default:                            misaligned = 1'b1;
        endcase
        return misaligned || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Word RAM built from one byte-wide array per lane: synchronous per-lane write, combinational read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           CLK,
    input  logic                           we,
    input  logic [BE_W-1:0]                be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [WORD_W-1:0]              wdata,
    output logic [WORD_W-1:0]              rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH_WORDS];

            always_ff @(posedge CLK) begin
                if (we && be[gi]) begin
                    r_lane[index] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = r_lane[index];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed LATENCY wait, one-cycle response pulse.
// Define MEM_RESP_BYTE_EN to add the REQ_BE port and byte-lane stores.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    input  logic              REQ_WRITE,
    input  logic [31:0]       REQ_ADDR,
    input  logic [WORD_W-1:0] REQ_WDATA,
`ifdef MEM_RESP_BYTE_EN
    input  logic [BE_W-1:0]   REQ_BE,
`endif
    output logic              REQ_READY,
    output logic              RSP_VALID,
    output logic [WORD_W-1:0] RSP_RDATA,
    output logic              RSP_ERR
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    logic              r_write;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [WORD_W-1:0] r_rdata, w_rdata_next;
    logic              r_err, w_err_next;

    logic [BE_W-1:0]   w_be_in;
    logic              w_sel_write;
    logic [31:0]       w_sel_addr;
    logic [BE_W-1:0]   w_sel_be;
    logic              w_acc_err;
    logic              w_load_rsp;
    logic              w_we;
    logic [IDX_W-1:0]  w_index;
    logic [WORD_W-1:0] w_rd_word;

`ifdef MEM_RESP_BYTE_EN
    assign w_be_in = REQ_BE;
`else
    assign w_be_in = {BE_W{1'b1}};
`endif

    // With LATENCY=0 the load result is registered on the accepting edge, so IDLE reads the live inputs.
    assign w_sel_write = (r_state == IDLE) ? REQ_WRITE : r_write;
    assign w_sel_addr  = (r_state == IDLE) ? REQ_ADDR  : r_addr;
    assign w_sel_be    = (r_state == IDLE) ? w_be_in   : r_be;
    assign w_acc_err   = check_err(w_sel_addr, w_sel_be, 32'(DEPTH_WORDS));
    assign w_index     = w_sel_addr[IDX_W+1:2];

    // Stores commit from the captured copy; a coincident reset cancels the write.
    assign w_we = !RST && r_write && !w_acc_err &&
                  (((r_state == WAIT) && (r_cnt == 4'd0)) ||
                   ((LATENCY == 0) && (r_state == RESP)));

    mem_resp_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .CLK   (CLK),
        .we    (w_we),
        .be    (r_be),
        .index (w_index),
        .wdata (r_wdata),
        .rdata (w_rd_word)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load_rsp   = 1'b0;
        w_rdata_next = '0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (REQ_VALID) begin
                    if (LATENCY == 0) begin
                        w_state_next = RESP;
                        w_load_rsp   = 1'b1;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = RESP;
                    w_load_rsp   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_load_rsp) begin
            w_err_next   = w_acc_err;
            w_rdata_next = (w_acc_err || w_sel_write) ? '0 : w_rd_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == IDLE && REQ_VALID) begin
            r_write <= REQ_WRITE;
            r_addr  <= REQ_ADDR;
            r_wdata <= REQ_WDATA;
            r_be    <= w_be_in;
        end
    end

    assign REQ_READY = (r_state == IDLE);
    assign RSP_VALID = (r_state == RESP);
    assign RSP_RDATA = r_rdata;
    assign RSP_ERR   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance 0 uses LATENCY=2, instance 1 uses LATENCY=0.
// Byte-lane vectors run only when MEM_RESP_BYTE_EN is defined.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid, req_write;
    logic [1:0][31:0] req_addr, req_wdata;
    logic [1:0][3:0]  req_be;
    logic [1:0]       req_ready, rsp_valid, rsp_err;
    logic [1:0][31:0] rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int last_rsp_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid[0]),
        .REQ_WRITE (req_write[0]),
        .REQ_ADDR  (req_addr[0]),
        .REQ_WDATA (req_wdata[0]),
`ifdef MEM_RESP_BYTE_EN
        .REQ_BE    (req_be[0]),
`endif
        .REQ_READY (req_ready[0]),
        .RSP_VALID (rsp_valid[0]),
        .RSP_RDATA (rsp_rdata[0]),
        .RSP_ERR   (rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) u_dut_b (
        .CLK       (clk),
        .RST       (rst),
        .REQ_VALID (req_valid[1]),
        .REQ_WRITE (req_write[1]),
        .REQ_ADDR  (req_addr[1]),
        .REQ_WDATA (req_wdata[1]),
`ifdef MEM_RESP_BYTE_EN
        .REQ_BE    (req_be[1]),
`endif
        .REQ_READY (req_ready[1]),
        .RSP_VALID (rsp_valid[1]),
        .RSP_RDATA (rsp_rdata[1]),
        .RSP_ERR   (rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one request starting at a falling edge; scramble inputs after acceptance, then check the response.
    task automatic req(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        int          exp_lat;
        bit          seen;
        logic [31:0] rd;
        logic        er;
        exp_lat      = (d == 0) ? LAT_A + 1 : LAT_B + 1;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        chk("ready_idle", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_write[d] = ~wr;
        req_addr[d]  = addr ^ 32'h4;
        req_wdata[d] = ~wdata;
        req_be[d]    = ~be;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        er   = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                seen = 1'b1;
                lat  = k;
                rd   = rsp_rdata[d];
                er   = rsp_err[d];
                last_rsp_cyc[d] = cyc;
                chk("ready_in_rsp", 32'(req_ready[d]), 32'd0);
            end
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        if (seen) begin
            $display("req dut%0d %s addr=%h wdata=%h be=%b -> rdata=%h err=%0d lat=%0d",
                     d, wr ? "ST" : "LD", addr, wdata, be, rd, er, lat);
            chk("rsp_latency", 32'(lat), 32'(exp_lat));
            chk("rsp_rdata", rd, exp_rdata);
            chk("rsp_err", 32'(er), 32'(exp_err));
            @(negedge clk);
            chk("pulse_end", 32'(rsp_valid[d]), 32'd0);
            chk("rdata_clr", rsp_rdata[d], 32'd0);
            chk("err_clr", 32'(rsp_err[d]), 32'd0);
        end
    endtask

    initial begin
        int stray;
        int t0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = {4'hF, 4'hF};
        rst       = 1'b1;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(req_ready[0]), 32'd1);
        chk("rst_ready_b", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid_a", 32'(rsp_valid[0]), 32'd0);
        chk("rst_rdata_a", rsp_rdata[0], 32'd0);
        chk("rst_err_a", 32'(rsp_err[0]), 32'd0);
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            stray += int'(rsp_valid[0]) + int'(rsp_valid[1]);
        end
        chk("idle_no_rsp", 32'(stray), 32'd0);
        $display("reset/idle done, stray responses=%0d", stray);

        // Store then load, LATENCY=2
        req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        req(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0);
        req(0, 1'b1, 32'h3FC, 32'h600DCAFE, 4'hF, 32'h0, 1'b0);
        req(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 32'h600DCAFE, 1'b0);

        // Errors: misaligned load, out-of-range store must leave word 0 alone
        req(0, 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
        req(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        req(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        req(0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h0BADF00D, 1'b0);
        req(0, 1'b0, 32'h400, 32'h0, 4'hF, 32'h0, 1'b1);

        // LATENCY=0: stores then back-to-back loads two cycles apart
        req(1, 1'b1, 32'h40, 32'hA5A50001, 4'hF, 32'h0, 1'b0);
        req(1, 1'b1, 32'h44, 32'h5A5A0002, 4'hF, 32'h0, 1'b0);
        req(1, 1'b0, 32'h40, 32'h0, 4'hF, 32'hA5A50001, 1'b0);
        t0 = last_rsp_cyc[1];
        req(1, 1'b0, 32'h44, 32'h0, 4'hF, 32'h5A5A0002, 1'b0);
        chk("b2b_spacing", 32'(last_rsp_cyc[1] - t0), 32'd2);
        req(1, 1'b0, 32'h2, 32'h0, 4'hF, 32'h0, 1'b1);

        // Reset one cycle after acceptance aborts the store
        req(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h12345678;
        req_be[0]    = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            stray += int'(rsp_valid[0]);
        end
        chk("rst_wait_no_rsp", 32'(stray), 32'd0);
        $display("reset in WAIT: responses after abort=%0d", stray);
        req(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0);

        // Reset on the commit edge wins over the write
        req(0, 1'b1, 32'h24, 32'h11111111, 4'hF, 32'h0, 1'b0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h24;
        req_wdata[0] = 32'h22222222;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            stray += int'(rsp_valid[0]);
        end
        chk("rst_commit_no_rsp", 32'(stray), 32'd0);
        $display("reset on commit edge: responses=%0d", stray);
        req(0, 1'b0, 32'h24, 32'h0, 4'hF, 32'h11111111, 1'b0);

`ifdef MEM_RESP_BYTE_EN
        req(0, 1'b1, 32'h30, 32'h11223344, 4'b1111, 32'h0, 1'b0);
        req(0, 1'b1, 32'h30, 32'h000000AA, 4'b0001, 32'h0, 1'b0);
        req(0, 1'b0, 32'h30, 32'h0, 4'b1111, 32'h112233AA, 1'b0);
        req(0, 1'b1, 32'h31, 32'h0000FFFF, 4'b0011, 32'h0, 1'b1);
        req(0, 1'b1, 32'h32, 32'hBBCC0000, 4'b1100, 32'h0, 1'b0);
        req(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b1);
        req(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1);
        req(0, 1'b0, 32'h30, 32'h0, 4'b1111, 32'hBBCC33AA, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
